// File: rtl/vcve2_fetch_align_fifo.sv
// Fetch word FIFO plus halfword realigner feeding the compressed decoder; optional same-cycle bypass via VCVE2_FETCH_FIFO_BYPASS_EN.
// Latency: a pushed word is presentable the next cycle (0 cycles with VCVE2_FETCH_FIFO_BYPASS_EN when empty and aligned).
// Backpressure: in_ready_o drops when all DEPTH entries are occupied or clear_i is high; it never depends on out_ready_i.
module vcve2_fetch_align_fifo #(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [31:0] branch_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [DEPTH-1:0] err_q;
  logic [DEPTH-1:0] err_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [31:0]      pc_q;
  logic [31:0]      pc_d;

  logic             has_one;
  logic             has_two;
  logic [31:0]      buf_rdata;
  logic             buf_valid;
  logic             buf_err;
  logic             bypass;
  logic             compressed;
  logic             push;
  logic             pop;
  logic             shift;
  logic [31:0]      pc_inc;
  logic [CW-1:0]    base;

  assign has_one = (count_q != '0);
  assign has_two = (count_q >= CW'(2));

  // Realign from the stored entries; an unaligned 32-bit instruction needs e1 unless e0 already faulted.
  always_comb begin
    buf_rdata = data_q[0];
    buf_valid = has_one;
    buf_err   = err_q[0];
    if (pc_q[1]) begin
      buf_rdata = {data_q[1][15:0], data_q[0][31:16]};
      if (data_q[0][17:16] != 2'b11) begin
        buf_valid = has_one;
        buf_err   = err_q[0];
      end else begin
        buf_valid = has_two | (has_one & err_q[0]);
        buf_err   = err_q[0] | (has_two & err_q[1]);
      end
    end
  end

`ifdef VCVE2_FETCH_FIFO_BYPASS_EN
  assign bypass = ~has_one & in_valid_i & ~pc_q[1] & ~clear_i;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid_o = bypass | buf_valid;
  assign out_rdata_o = bypass ? in_rdata_i : buf_rdata;
  assign out_err_o   = bypass ? in_err_i : (buf_valid & buf_err);
  assign out_addr_o  = pc_q;
  assign in_ready_o  = (count_q < CW'(DEPTH)) & ~clear_i;

  assign compressed  = (out_rdata_o[1:0] != 2'b11);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i & ~clear_i;
  assign pc_inc      = pc_q + (compressed ? 32'd2 : 32'd4);
  assign shift       = (pc_inc[31:2] != pc_q[31:2]);

  always_comb begin
    data_d  = data_q;
    err_d   = err_q;
    count_d = count_q;
    pc_d    = pc_q;
    base    = count_q;
    if (clear_i) begin
      count_d = '0;
      pc_d    = branch_addr_i & 32'hFFFF_FFFE;
    end else begin
      if (pop) begin
        pc_d = pc_inc;
      end
      if (pop && out_err_o) begin
        // Faulting instruction: drop everything, the consumer will redirect.
        count_d = '0;
      end else if (bypass && pop && shift) begin
        // Bypassed word fully consumed in flight; nothing to store.
        count_d = '0;
      end else begin
        if (pop && shift) begin
          for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            data_d[i] = data_q[i+1];
            err_d[i]  = err_q[i+1];
          end
          base = count_q - CW'(1);
        end
        if (push) begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            if (CW'(i) == base) begin
              data_d[i] = in_rdata_i;
              err_d[i]  = in_err_i;
            end
          end
          base = base + CW'(1);
        end
        count_d = base;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
      end
      err_q   <= '0;
      count_q <= '0;
      pc_q    <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= data_d[i];
      end
      err_q   <= err_d;
      count_q <= count_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_vcve2_fetch_align_fifo.sv
// Directed scenarios plus a randomized run against a queue-of-words reference model of the fetch stream.
module tb_vcve2_fetch_align_fifo;

  localparam int DEPTH = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_rdata_i = '0;
  logic        in_err_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;

  int errors = 0;
  int checks = 0;

  // Reference model: queued words as {err, data} and the current PC.
  logic [32:0] mq[$];
  logic [31:0] mpc;

  vcve2_fetch_align_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .branch_addr_i(branch_addr_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_rdata_i(in_rdata_i), .in_err_i(in_err_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_rdata_o(out_rdata_o),
    .out_addr_o(out_addr_o), .out_err_o(out_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic clr, input logic [31:0] ba, input logic iv,
                        input logic [31:0] id, input logic ie, input logic ordy);
    clear_i = clr; branch_addr_i = ba; in_valid_i = iv;
    in_rdata_i = id; in_err_i = ie; out_ready_i = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Presented instruction derived from the halfword stream at mpc.
  task automatic model_eval(input logic clr, input logic iv, input logic [31:0] id, input logic ie,
                            output logic v, output logic [31:0] rd, output logic er, output logic cmp);
    logic [32:0] w0, w1;
    logic [15:0] lo;
    int n;
    n  = mq.size();
    w0 = (n > 0) ? mq[0] : 33'h0;
    w1 = (n > 1) ? mq[1] : 33'h0;
`ifdef VCVE2_FETCH_FIFO_BYPASS_EN
    if (n == 0 && iv && !mpc[1] && !clr) begin n = 1; w0 = {ie, id}; end
`else
    if (clr && iv && ie && id[0]) n = n;
`endif
    v = 1'b0; rd = 32'h0; er = 1'b0; cmp = 1'b0;
    if (n > 0) begin
      if (!mpc[1]) begin
        rd = w0[31:0]; v = 1'b1; er = w0[32];
      end else begin
        lo = w0[31:16];
        rd = {w1[15:0], lo};
        if (lo[1:0] != 2'b11) begin v = 1'b1; er = w0[32]; end
        else if (n >= 2) begin v = 1'b1; er = w0[32] | w1[32]; end
        else if (w0[32]) begin v = 1'b1; er = 1'b1; end
      end
      cmp = (rd[1:0] != 2'b11);
    end
  endtask

  task automatic model_step(input logic clr, input logic [31:0] ba, input logic iv,
                            input logic [31:0] id, input logic ie, input logic ordy,
                            input logic v, input logic er, input logic cmp);
    int hw;
    if (clr) begin
      mq.delete();
      mpc = ba & 32'hFFFF_FFFE;
    end else begin
      if (iv && mq.size() < DEPTH) mq.push_back({ie, id});
      if (v && ordy) begin
        hw = cmp ? 1 : 2;
        if (er) mq.delete();
        else if (int'(mpc[1]) + hw >= 2) void'(mq.pop_front());
        mpc = mpc + 32'(hw * 2);
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready_o); end
    checks++; if (out_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", out_addr_o); end
    checks++; if (out_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", out_err_o); end
    checks++; if (out_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", out_rdata_o); end
    tick(); tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_aligned();
    set_in(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b1, 32'h00A00093, 1'b0, 1'b0);
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL aligned_ready: got %b want 1", in_ready_o); end
    tick();
    idle();
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL aligned_valid: got %b want 1", out_valid_o); end
    checks++; if (out_rdata_o !== 32'h00A00093) begin errors++; $display("FAIL aligned_rdata: got %h want 00a00093", out_rdata_o); end
    checks++; if (out_addr_o !== 32'h100) begin errors++; $display("FAIL aligned_addr: got %h want 100", out_addr_o); end
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1); tick();
    idle();
    checks++; if (out_addr_o !== 32'h104) begin errors++; $display("FAIL aligned_pop_addr: got %h want 104", out_addr_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL aligned_pop_empty: got %b want 0", out_valid_o); end
  endtask

  task automatic test_compressed_pair();
    set_in(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b1, 32'h45014505, 1'b0, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (out_valid_o !== 1'b1 || out_rdata_o[15:0] !== 16'h4505 || out_addr_o !== 32'h100) begin
      errors++; $display("FAIL cpair_first: got v=%b d=%h a=%h want v=1 d=4505 a=100", out_valid_o, out_rdata_o[15:0], out_addr_o); end
    tick();
    checks++; if (out_valid_o !== 1'b1 || out_rdata_o[15:0] !== 16'h4501 || out_addr_o !== 32'h102) begin
      errors++; $display("FAIL cpair_second: got v=%b d=%h a=%h want v=1 d=4501 a=102", out_valid_o, out_rdata_o[15:0], out_addr_o); end
    tick();
    idle();
    checks++; if (out_valid_o !== 1'b0 || out_addr_o !== 32'h104) begin
      errors++; $display("FAIL cpair_done: got v=%b a=%h want v=0 a=104", out_valid_o, out_addr_o); end
  endtask

  task automatic test_straddle();
    set_in(1'b1, 32'h102, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b1, 32'h00930000, 1'b0, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b1, 32'h000000A0, 1'b0, 1'b0);
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL straddle_half: got v=%b want 0", out_valid_o); end
    tick();
    idle();
    checks++; if (out_valid_o !== 1'b1 || out_rdata_o !== 32'h00A00093 || out_addr_o !== 32'h102) begin
      errors++; $display("FAIL straddle_full: got v=%b d=%h a=%h want v=1 d=00a00093 a=102", out_valid_o, out_rdata_o, out_addr_o); end
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1); tick();
    idle();
    checks++; if (out_addr_o !== 32'h106 || out_valid_o !== 1'b1 || out_rdata_o[15:0] !== 16'h0000) begin
      errors++; $display("FAIL straddle_rest: got v=%b d=%h a=%h want v=1 d=0000 a=106", out_valid_o, out_rdata_o[15:0], out_addr_o); end
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1); tick();
    idle();
    checks++; if (out_valid_o !== 1'b0 || out_addr_o !== 32'h108) begin
      errors++; $display("FAIL straddle_drain: got v=%b a=%h want v=0 a=108", out_valid_o, out_addr_o); end
  endtask

  task automatic test_full();
    logic [31:0] w;
    set_in(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    for (int i = 0; i < DEPTH; i++) begin
      w = 32'h00000013 | (32'(i + 1) << 20);
      set_in(1'b0, 32'h0, 1'b1, w, 1'b0, 1'b0);
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %b want 1", i, in_ready_o); end
      tick();
    end
    set_in(1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL full_not_ready: got %b want 0", in_ready_o); end
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL full_no_comb_ready: got %b want 0", in_ready_o); end
    for (int i = 0; i < DEPTH; i++) begin
      w = 32'h00000013 | (32'(i + 1) << 20);
      checks++; if (out_valid_o !== 1'b1 || out_rdata_o !== w) begin
        errors++; $display("FAIL full_drain_%0d: got v=%b d=%h want v=1 d=%h", i, out_valid_o, out_rdata_o, w); end
      tick();
      if (i == 0) begin
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL full_reready: got %b want 1", in_ready_o); end
      end
    end
    idle();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL full_overflow_word: got v=%b d=%h want v=0", out_valid_o, out_rdata_o); end
  endtask

  task automatic test_error();
    set_in(1'b1, 32'h102, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b1, 32'h00030000, 1'b1, 1'b0); tick();
    idle();
    checks++; if (out_valid_o !== 1'b1 || out_err_o !== 1'b1 || out_addr_o !== 32'h102) begin
      errors++; $display("FAIL err_early: got v=%b e=%b a=%h want v=1 e=1 a=102", out_valid_o, out_err_o, out_addr_o); end
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1); tick();
    idle();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL err_flush: got v=%b want 0", out_valid_o); end
    set_in(1'b1, 32'h200, 1'b1, 32'h12345678, 1'b0, 1'b0);
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL clear_ready: got %b want 0", in_ready_o); end
    tick();
    idle();
    checks++; if (out_valid_o !== 1'b0 || out_addr_o !== 32'h200) begin
      errors++; $display("FAIL clear_drop: got v=%b a=%h want v=0 a=200", out_valid_o, out_addr_o); end
    set_in(1'b0, 32'h0, 1'b1, 32'h00000013, 1'b0, 1'b0); tick();
    idle();
    checks++; if (out_valid_o !== 1'b1 || out_rdata_o !== 32'h00000013) begin
      errors++; $display("FAIL clear_next_word: got v=%b d=%h want v=1 d=00000013", out_valid_o, out_rdata_o); end
  endtask

  task automatic test_wrap();
    set_in(1'b1, 32'h301, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    idle();
    checks++; if (out_addr_o !== 32'h300) begin errors++; $display("FAIL branch_bit0: got %h want 300", out_addr_o); end
    set_in(1'b1, 32'hFFFFFFFE, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b1, 32'h45050000, 1'b0, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (out_valid_o !== 1'b1 || out_rdata_o[15:0] !== 16'h4505 || out_addr_o !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL wrap_present: got v=%b d=%h a=%h want v=1 d=4505 a=fffffffe", out_valid_o, out_rdata_o[15:0], out_addr_o); end
    tick();
    idle();
    checks++; if (out_addr_o !== 32'h0 || out_valid_o !== 1'b0) begin
      errors++; $display("FAIL wrap_pc: got v=%b a=%h want v=0 a=0", out_valid_o, out_addr_o); end
  endtask

  task automatic test_async_reset();
    set_in(1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b1, 32'h00000013, 1'b0, 1'b0); tick();
    idle();
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (out_valid_o !== 1'b0 || out_addr_o !== 32'h0 || in_ready_o !== 1'b1) begin
      errors++; $display("FAIL async_reset: got v=%b a=%h r=%b want v=0 a=0 r=1", out_valid_o, out_addr_o, in_ready_o); end
    #2;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic clr, iv, ie, ordy, v, er, cmp, rdy;
    logic [31:0] ba, id, rd;
    set_in(1'b1, 32'h1000, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    mq.delete();
    mpc = 32'h1000;
    for (int n = 0; n < 3000; n++) begin
      clr  = ($urandom_range(0, 31) == 0);
      ba   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF8 | ($urandom & 32'h7)) : $urandom;
      iv   = ($urandom_range(0, 9) < 7);
      id   = $urandom;
      if ($urandom_range(0, 1) == 1) id[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) id[17:16] = 2'b11;
      ie   = ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 9) < 6);
      set_in(clr, ba, iv, id, ie, ordy);
      model_eval(clr, iv, id, ie, v, rd, er, cmp);
      rdy = (mq.size() < DEPTH) && !clr;
      checks++; if (in_ready_o !== rdy) begin errors++; $display("FAIL rnd_ready @%0d: got %b want %b", n, in_ready_o, rdy); end
      checks++; if (out_valid_o !== v) begin errors++; $display("FAIL rnd_valid @%0d: got %b want %b", n, out_valid_o, v); end
      if (v) begin
        checks++; if (out_addr_o !== mpc) begin errors++; $display("FAIL rnd_addr @%0d: got %h want %h", n, out_addr_o, mpc); end
        checks++; if (out_err_o !== er) begin errors++; $display("FAIL rnd_err @%0d: got %b want %b", n, out_err_o, er); end
        if (cmp || er) begin
          checks++; if (out_rdata_o[15:0] !== rd[15:0]) begin errors++; $display("FAIL rnd_rdata16 @%0d: got %h want %h", n, out_rdata_o[15:0], rd[15:0]); end
        end else begin
          checks++; if (out_rdata_o !== rd) begin errors++; $display("FAIL rnd_rdata32 @%0d: got %h want %h", n, out_rdata_o, rd); end
        end
      end
      tick();
      model_step(clr, ba, iv, id, ie, ordy, v, er, cmp);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_compressed_pair();
    test_straddle();
    test_full();
    test_error();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vcve2_fetch_align_fifo.md
Name: vcve2_fetch_align_fifo

Overview:
- Instruction fetch buffer plus realigner, sitting directly upstream of the compressed decoder.
- Accepts word-aligned 32-bit fetch responses from the instruction memory interface and queues them.
- Presents one instruction per handshake at its PC, which may be halfword-aligned: a 16-bit compressed instruction in bits [15:0], or a full 32-bit instruction that may straddle two fetch words.
- Tracks the PC of the presented instruction and flushes on control-flow changes.

Parameters:
DEPTH, 3, number of 32-bit fetch-word entries (minimum 2).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  flush all entries; load PC from branch_addr_i
branch_addr_i  in  32  new PC on clear_i (bit 0 ignored, treated as 0)
in_valid_i  in  1  fetch response valid
in_ready_o  out  1  FIFO can accept a word
in_rdata_i  in  32  word-aligned fetch data
in_err_i  in  1  bus error on this fetch word
out_valid_o  out  1  complete instruction available
out_ready_i  in  1  consumer takes instruction
out_rdata_o  out  32  realigned instruction; [31:16] undefined-but-stable for compressed
out_addr_o  out  32  PC of out_rdata_o
out_err_o  out  1  fetch error associated with the presented instruction

Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.

Behaviour:
- Reset: count=0, pc_q=0, all entries invalid; in_ready_o=1, out_valid_o=0, out_err_o=0, out_addr_o=0, out_rdata_o=0.
- Storage: entries e[0..DEPTH-1] of {data[31:0], err}; e[0] is oldest; count in 0..DEPTH.
- Push: in_valid_i & in_ready_o writes e[count]. in_ready_o = (count<DEPTH) & ~clear_i; no combinational path from out_ready_i.
- Latency: a pushed word is presentable the cycle after the push.
- Realignment, pc_q[1]=0:
  - out_rdata_o = e0.data.
  - out_valid_o = count>=1.
  - out_err_o = e0.err.
- Realignment, pc_q[1]=1:
  - out_rdata_o[15:0] = e0.data[31:16]; out_rdata_o[31:16] = e1.data[15:0].
  - Compressed if e0.data[17:16] != 2'b11, in which case valid with count>=1.
  - Uncompressed: valid with count>=2, or with count>=1 if e0.err=1 (error reported early).
  - out_err_o = e0.err | (uncompressed & count>=2 & e1.err).
- Compression test: bits [1:0] of out_rdata_o != 2'b11.
- Pop on out_valid_o & out_ready_i:
  - pc_q += 2 if compressed, else 4.
  - If new pc_q[31:2] != old pc_q[31:2], shift out e0 (count-1).
  - Unaligned uncompressed pops exactly e0; e1 becomes e0 with its lower half consumed.
  - If out_err_o=1 on pop, discard all entries (count=0); the consumer is expected to trap/clear.
- Simultaneous push and pop in one cycle: shift and write to e[count-1]; count unchanged.
- clear_i has priority over push and pop:
  - Next cycle count=0 and pc_q=branch_addr_i with bit 0 forced to 0.
  - A same-cycle input word is dropped (in_ready_o=0).
  - out_valid_o=0 in the cycle after clear_i.
- Branch to unaligned target (pc[1]=1): the lower half of the first fetched word is ignored by construction.
- Full: count==DEPTH forces in_ready_o=0; no overflow possible.
- PC wrap: pc_q increments modulo 2^32; 0xFFFFFFFE + 2 = 0x00000000.
- Asynchronous reset mid-operation returns all state to reset values immediately.

Optional Feature:
- Macro: VCVE2_FETCH_FIFO_BYPASS_EN.
- Defined: when count==0, in_valid_i=1, pc_q[1]=0, and either in_err_i=1 or the incoming word is compressed or aligned-uncompressed, the word is presented combinationally in the same cycle:
  - out_valid_o=1, out_rdata_o=in_rdata_i, out_err_o=in_err_i.
  - If out_ready_i is also high and the whole word is consumed, nothing is stored. Otherwise the word is pushed as normal.
- Not defined: no combinational in->out path; minimum latency is 1 cycle.

Test Plan:
- Reset, no stimulus -> out_valid_o=0, in_ready_o=1, out_addr_o=0.
- clear_i with branch_addr_i=0x100, then push 0x00A00093 -> next cycle out_valid_o=1, out_rdata_o=0x00A00093, out_addr_o=0x100; on pop, out_addr_o=0x104 and count=0.
- clear_i to 0x100, push 0x45014505 (two c.li), out_ready_i=1 -> out_rdata_o[15:0]=0x4505 at 0x100, then 0x4501 at 0x102; word popped after the second.
- clear_i to 0x102, push 0x00930000 then 0x000000A0 -> no valid after the first word alone; after the second, out_rdata_o=0x00A00093, out_addr_o=0x102; pop leaves count=1, out_addr_o=0x106.
- Push DEPTH words with out_ready_i=0 -> in_ready_o=0 after the 3rd; a further in_valid_i is not accepted; one pop re-raises in_ready_o.
- clear_i to 0x102, push word with in_err_i=1, lower half 32-bit opcode -> out_valid_o=1, out_err_o=1 with count=1; pop empties the FIFO. A clear_i asserted together with a push -> word dropped, count=0.
